// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes on both sides.
// Define BIN2BCD_SEVSEG_EN to add a registered gfedcba seven-segment output alongside bcd.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
`ifdef BIN2BCD_SEVSEG_EN
    output logic [7*DIGITS-1:0]   seg,
`endif
    output logic                  busy
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p = 64'd1;
        for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam longint unsigned BIN_MAX = (64'(1) << BIN_W) - 64'(1);

    if (BIN_W < 1 || pow10(DIGITS) <= BIN_MAX) begin : g_param_err
        $error("bin2bcd_seq: BIN_W must be >= 1 and 10**DIGITS must exceed 2**BIN_W-1");
    end

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_adj;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef BIN2BCD_SEVSEG_EN
    logic [7*DIGITS-1:0] seg_q, seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction
`endif

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            bcd_q       <= '0;
            acc_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
`ifdef BIN2BCD_SEVSEG_EN
            seg_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            bcd_q       <= bcd_d;
            acc_q       <= acc_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
`ifdef BIN2BCD_SEVSEG_EN
            seg_q       <= seg_d;
`endif
        end
    end

    // Add-3 correction applied to every digit >= 5 before the shift
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    // Next state and shift datapath
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    bin_d   = bin_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_valid_q && out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; result is published one cycle after the final shift
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d == S_SHIFT);
        out_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
        bcd_d       = bcd_q;
`ifdef BIN2BCD_SEVSEG_EN
        seg_d       = seg_q;
`endif
        if (state_q == S_DONE && !out_valid_q) begin
            bcd_d = acc_q;
`ifdef BIN2BCD_SEVSEG_EN
            for (int i = 0; i < int'(DIGITS); i++) seg_d[7*i +: 7] = seg7(acc_q[4*i +: 4]);
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bcd       = bcd_q;
`ifdef BIN2BCD_SEVSEG_EN
    assign seg       = seg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 8-bit/3-digit and 4-bit/2-digit instances checked against a division-based model.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  bin_in;
    logic [11:0] bcd;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  bin_in4;
    logic [7:0]  bcd4;
`ifdef BIN2BCD_SEVSEG_EN
    logic [20:0] seg;
    logic [13:0] seg4;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  exp4_q[$];

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
        .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd),
`ifdef BIN2BCD_SEVSEG_EN
        .seg(seg),
`endif
        .busy(busy)
    );

    bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .bin_in(bin_in4),
        .out_valid(out_valid4), .out_ready(out_ready4), .bcd(bcd4),
`ifdef BIN2BCD_SEVSEG_EN
        .seg(seg4),
`endif
        .busy(busy4)
    );

    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one value into the 8-bit instance and return the result once presented.
    task automatic run8(input logic [7:0] v, output logic [11:0] got, output bit ok);
        logic [15:0] e;
        ok = 1'b0;
        got = '0;
        out_ready = 1'b1;
        bin_in = v;
        in_valid = 1'b1;
        e = ref_bcd(32'(v));
        exp_q.push_back(e[11:0]);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                got = bcd;
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) step();
    endtask

    task automatic run4(input logic [3:0] v, output logic [7:0] got, output bit ok);
        logic [15:0] e;
        ok = 1'b0;
        got = '0;
        out_ready4 = 1'b1;
        bin_in4 = v;
        in_valid4 = 1'b1;
        e = ref_bcd(32'(v));
        exp4_q.push_back(e[7:0]);
        if (!in_ready4) begin
            in_valid4 = 1'b0;
            return;
        end
        step();
        in_valid4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid4) begin
                got = bcd4;
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; bin_in = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; bin_in4 = '0;
        step();
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 000", bcd); end
        n_checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || bcd4 !== 8'h00) begin
            n_fail++; $display("FAIL reset_dut4: got rdy=%b vld=%b busy=%b bcd=%h expected 1 0 0 00", in_ready4, out_valid4, busy4, bcd4);
        end
`ifdef BIN2BCD_SEVSEG_EN
        n_checks++; if (seg !== 21'h0 || seg4 !== 14'h0) begin n_fail++; $display("FAIL reset_seg: got %h/%h expected 0", seg, seg4); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        int lat = 0;
        int busy_cnt = 0;
        bit seen = 1'b0;
        logic [15:0] e;
        logic [11:0] exp;
        out_ready = 1'b1;
        bin_in = 8'd255;
        in_valid = 1'b1;
        e = ref_bcd(255);
        exp_q.push_back(e[11:0]);
        step();
        in_valid = 1'b0;
        bin_in = 8'd3;
        if (busy) busy_cnt++;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (busy) busy_cnt++;
            if (out_valid) begin
                lat = i;
                seen = 1'b1;
                break;
            end
        end
        exp = exp_q.pop_front();
        n_checks++; if (!seen || lat != 9) begin n_fail++; $display("FAIL latency: got %0d edges expected 9", lat); end
        n_checks++; if (busy_cnt != 8) begin n_fail++; $display("FAIL busy_cycles: got %0d expected 8", busy_cnt); end
        n_checks++; if (bcd !== exp) begin n_fail++; $display("FAIL bcd_255: got %h expected %h", bcd, exp); end
        step();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL after_handshake: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        n_checks++; if (bcd !== exp) begin n_fail++; $display("FAIL bcd_hold_idle: got %h expected %h", bcd, exp); end
    endtask

    task automatic test_values();
        logic [7:0] vals[8] = '{8'd0, 8'd99, 8'd100, 8'd109, 8'd1, 8'd10, 8'd254, 8'd128};
        logic [11:0] got, exp;
        bit ok;
        foreach (vals[k]) begin
            run8(vals[k], got, ok);
            exp = exp_q.pop_front();
            n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL value_%0d: got %h ok=%b expected %h", vals[k], got, ok, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        logic [11:0] exp, got;
        bit ok = 1'b0;
        out_ready = 1'b0;
        bin_in = 8'd42;
        in_valid = 1'b1;
        e = ref_bcd(42);
        exp_q.push_back(e[11:0]);
        step();
        bin_in = 8'd7;
        for (int i = 0; i < 40 && !out_valid; i++) step();
        exp = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (bcd !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold_%0d: got bcd=%h rdy=%b vld=%b expected %h 0 1", c, bcd, in_ready, out_valid, exp);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        end
        e = ref_bcd(7);
        exp_q.push_back(e[11:0]);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin got = bcd; ok = 1'b1; break; end
            step();
        end
        exp = exp_q.pop_front();
        n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL bp_second: got %h ok=%b expected %h", got, ok, exp); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        logic [11:0] got, exp;
        bit ok;
        out_ready = 1'b1;
        bin_in = 8'd200;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || bcd !== 12'h000 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got vld=%b bcd=%h rdy=%b busy=%b expected 0 000 1 0", out_valid, bcd, in_ready, busy);
        end
        run8(8'd200, got, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL after_abort_200: got %h ok=%b expected %h", got, ok, exp); end
    endtask

    task automatic test_sweep();
        logic [11:0] got, exp;
        bit ok;
        for (int v = 0; v < 256; v++) begin
            run8(8'(v), got, ok);
            exp = exp_q.pop_front();
            n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL sweep8_%0d: got %h ok=%b expected %h", v, got, ok, exp); end
        end
    endtask

    task automatic test_sweep4();
        logic [7:0] got, exp;
        bit ok;
        for (int v = 0; v < 16; v++) begin
            run4(4'(v), got, ok);
            exp = exp4_q.pop_front();
            n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL sweep4_%0d: got %h ok=%b expected %h", v, got, ok, exp); end
        end
    endtask

`ifdef BIN2BCD_SEVSEG_EN
    task automatic test_sevseg();
        logic [11:0] got, exp;
        bit ok;
        run8(8'd38, got, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL seg_bcd_38: got %h expected %h", got, exp); end
        n_checks++; if (seg !== {7'h3F, 7'h4F, 7'h7F}) begin n_fail++; $display("FAIL seg_38: got %h expected %h", seg, {7'h3F, 7'h4F, 7'h7F}); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_sweep4();
`ifdef BIN2BCD_SEVSEG_EN
        test_sevseg();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
